// File: rtl/uart_frame_transmitter_pkg.sv
// Shared definitions for the UART frame transmitter: FSM states, baud table
// and frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 11;

  // Indexed by baud_select.
  localparam int unsigned BAUD_TABLE [8] = '{
    300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // Clocks per bit for a given code; only ever evaluated on constants.
  function automatic int unsigned bit_period(input int unsigned clk_freq,
                                             input int unsigned code);
    return clk_freq / BAUD_TABLE[code];
  endfunction

endpackage

// File: rtl/uart_frame_transmitter_if.sv
// Handshake and serial-line bundle between the encoder side and the transmitter.
interface uart_frame_transmitter_if;

  logic       tx_en;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic [2:0] baud_select;
  logic       tx_d;
  logic       tx_busy;

  modport master (
    output tx_en, tx_wr, tx_data, baud_select,
    input  tx_d, tx_busy
  );

  modport slave (
    input  tx_en, tx_wr, tx_data, baud_select,
    output tx_d, tx_busy
  );

endinterface

// File: rtl/uart_frame_transmitter_baud_controller.sv
// Bit-period counter: counts 0..P-1 for the selected code and pulses bit_tick
// on the last count. clear holds the counter at zero.
module baud_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       clear,
  output logic       bit_tick
);

  localparam int unsigned P_MAX = bit_period(CLK_FREQ, 0);
  localparam int unsigned CNT_W = (P_MAX > 1) ? $clog2(P_MAX) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Terminal count per code, folded to constants so no divider is built.
  localparam cnt_t LAST_TAB [8] = '{
    cnt_t'(bit_period(CLK_FREQ, 0) - 1),
    cnt_t'(bit_period(CLK_FREQ, 1) - 1),
    cnt_t'(bit_period(CLK_FREQ, 2) - 1),
    cnt_t'(bit_period(CLK_FREQ, 3) - 1),
    cnt_t'(bit_period(CLK_FREQ, 4) - 1),
    cnt_t'(bit_period(CLK_FREQ, 5) - 1),
    cnt_t'(bit_period(CLK_FREQ, 6) - 1),
    cnt_t'(bit_period(CLK_FREQ, 7) - 1)
  };

  cnt_t cnt_q;
  cnt_t cnt_d;
  cnt_t last;

  always_comb begin
    last     = LAST_TAB[baud_select];
    cnt_d    = cnt_q + cnt_t'(1);
    bit_tick = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == last) begin
      cnt_d    = '0;
      bit_tick = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_transmitter.sv
// Serialises one encoded byte per handshake as start, 8 data bits LSB-first,
// even parity and stop, at a run-time selectable bit rate.
module uart_frame_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input logic                     clk,
  input logic                     reset,
  uart_frame_transmitter_if.slave bus
);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] baud_q, baud_d;
  logic [2:0] idx_q, idx_d;
  logic       parity_q, parity_d;
  logic       tx_d_q, tx_d_d;
  logic       busy_q, busy_d;

  logic       clear;
  logic       bit_tick;

  baud_controller #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_q),
    .clear       (clear),
    .bit_tick    (bit_tick)
  );

  // Acceptance is gated on the FSM being idle; tx_busy is the registered
  // view of that, which yields a single idle-high clock between frames.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    clear    = 1'b0;

    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (bus.tx_en && bus.tx_wr) begin
          data_d   = bus.tx_data;
          baud_d   = bus.baud_select;
          parity_d = ^bus.tx_data;
          idx_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        if (bit_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level and busy flag are registered from the current state so the
  // output never glitches; they trail the state register by one clock.
  always_comb begin
    tx_d_d = 1'b1;
    unique case (state_q)
      IDLE:    tx_d_d = 1'b1;
      START:   tx_d_d = 1'b0;
      DATA:    tx_d_d = data_q[idx_q];
      PARITY:  tx_d_d = parity_q;
      STOP:    tx_d_d = 1'b1;
      default: tx_d_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      baud_q   <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx_d_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      tx_d_q   <= tx_d_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.tx_d    = tx_d_q;
  assign bus.tx_busy = busy_q;

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Directed bench for uart_frame_transmitter at CLK_FREQ=1_152_000
// (10 clocks per bit at code 7, 3840 at code 0).
module tb_uart_frame_transmitter;

  logic clk = 1'b0;
  logic reset;

  uart_frame_transmitter_if bus ();

  uart_frame_transmitter #(
    .CLK_FREQ (1_152_000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Mid-frame stimulus applied by expect_frame at frame cycle inj_cyc.
  int         inj_cyc;
  logic [7:0] inj_data;
  logic [2:0] inj_baud;
  logic       inj_wr;
  logic       inj_en;
  logic       inj_wr_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_wr();
    bus.tx_wr = 1'b1;
    tick();
    bus.tx_wr = 1'b0;
  endtask

  task automatic wait_busy(input string tag, output int idle);
    idle = 0;
    while (bus.tx_busy !== 1'b1 && idle < 200) begin
      tick();
      idle++;
    end
    check({tag, "_start"}, 32'(bus.tx_busy), 32'd1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int busy_cnt;
    int low_cnt;
    busy_cnt = 0;
    low_cnt  = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.tx_busy !== 1'b0) busy_cnt++;
      if (bus.tx_d !== 1'b1) low_cnt++;
      tick();
    end
    check({tag, "_no_busy"}, 32'(busy_cnt), 32'd0);
    check({tag, "_line_high"}, 32'(low_cnt), 32'd0);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] data, input logic par,
                              input int p, input int idle_exp);
    int          idle;
    int          bad;
    int          c;
    logic [10:0] bits;
    bits = {1'b1, par, data, 1'b0};
    wait_busy(tag, idle);
    check({tag, "_idle"}, 32'(idle), 32'(idle_exp));
    c = 0;
    for (int b = 0; b < 11; b++) begin
      bad = 0;
      for (int j = 0; j < p; j++) begin
        if (bus.tx_d !== bits[b] || bus.tx_busy !== 1'b1) bad++;
        if (inj_cyc >= 0 && c == inj_cyc) begin
          bus.tx_data     = inj_data;
          bus.baud_select = inj_baud;
          bus.tx_wr       = inj_wr;
          bus.tx_en       = inj_en;
        end
        if (inj_cyc >= 0 && c == inj_cyc + 1) bus.tx_wr = inj_wr_after;
        c++;
        tick();
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(bad), 32'd0);
    end
    check({tag, "_busy_end"}, 32'(bus.tx_busy), 32'd0);
    check({tag, "_line_end"}, 32'(bus.tx_d), 32'd1);
  endtask

  task automatic run_length(input string tag, input logic level, input int exp);
    int n;
    n = 0;
    while (bus.tx_d === level && bus.tx_busy === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int idle;

    reset           = 1'b1;
    bus.tx_en       = 1'b0;
    bus.tx_wr       = 1'b0;
    bus.tx_data     = 8'h00;
    bus.baud_select = 3'd7;
    inj_cyc         = -1;
    inj_data        = 8'h00;
    inj_baud        = 3'd7;
    inj_wr          = 1'b0;
    inj_en          = 1'b1;
    inj_wr_after    = 1'b0;

    // Reset values before any clock edge
    #2;
    check("reset_tx_d", 32'(bus.tx_d), 32'd1);
    check("reset_busy", 32'(bus.tx_busy), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single 0x23 frame; a 0xFF write mid-frame must be ignored
    bus.tx_en   = 1'b1;
    bus.tx_data = 8'h23;
    inj_cyc     = 40;
    inj_data    = 8'hFF;
    inj_baud    = 3'd7;
    inj_wr      = 1'b1;
    inj_en      = 1'b1;
    pulse_wr();
    expect_frame("single", 8'h23, 1'b1, 10, 1);
    quiet("after_single", 30);

    // Write with enable low produces nothing
    inj_cyc     = -1;
    bus.tx_en   = 1'b0;
    bus.tx_data = 8'h23;
    pulse_wr();
    quiet("en_low", 30);

    // Dropping enable mid-frame does not abort the frame
    bus.tx_en   = 1'b1;
    bus.tx_data = 8'hA5;
    inj_cyc     = 55;
    inj_data    = 8'hA5;
    inj_wr      = 1'b0;
    inj_en      = 1'b0;
    pulse_wr();
    expect_frame("en_drop", 8'hA5, 1'b0, 10, 1);
    bus.tx_en = 1'b1;
    quiet("after_en_drop", 20);

    // Back-to-back with tx_wr held high
    inj_cyc     = -1;
    bus.tx_data = 8'h00;
    bus.tx_wr   = 1'b1;
    tick();
    expect_frame("b2b_1", 8'h00, 1'b0, 10, 1);
    inj_cyc  = 5;
    inj_data = 8'h00;
    inj_wr   = 1'b0;
    inj_en   = 1'b1;
    expect_frame("b2b_2", 8'h00, 1'b0, 10, 1);
    quiet("after_b2b", 20);

    // Data and baud changed mid-frame take effect only on the next frame
    bus.tx_data     = 8'h23;
    bus.baud_select = 3'd7;
    inj_cyc         = 25;
    inj_data        = 8'h59;
    inj_baud        = 3'd0;
    inj_wr          = 1'b0;
    inj_en          = 1'b1;
    pulse_wr();
    expect_frame("stable", 8'h23, 1'b1, 10, 1);
    inj_cyc = -1;
    pulse_wr();
    wait_busy("slow", idle);
    run_length("slow_start_len", 1'b0, 3840);
    run_length("slow_bit0_len", 1'b1, 3840);
    reset = 1'b1;
    #1;
    check("slow_abort_busy", 32'(bus.tx_busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Reset during DATA bit 3 of a 0x23 frame
    bus.baud_select = 3'd7;
    bus.tx_data     = 8'h23;
    pulse_wr();
    wait_busy("rst_frame", idle);
    for (int i = 0; i < 45; i++) tick();
    check("rst_pre_bit3", 32'(bus.tx_d), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_async_tx_d", 32'(bus.tx_d), 32'd1);
    check("rst_async_busy", 32'(bus.tx_busy), 32'd0);
    bus.tx_wr = 1'b1;
    tick();
    tick();
    check("rst_held_busy", 32'(bus.tx_busy), 32'd0);
    bus.tx_wr = 1'b0;
    reset     = 1'b0;
    quiet("after_rst", 5);
    pulse_wr();
    expect_frame("post_rst", 8'h23, 1'b1, 10, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_frame_transmitter.md
# uart_frame_transmitter

Serial transmit stage that sits directly downstream of the nibble encoder in the transmitter path. It accepts one encoded 8-bit word per handshake and serialises it onto a single line as a UART-style frame: one start bit, 8 data bits LSB-first, an even-parity bit and one stop bit. The bit rate is selectable at run time. The receiver side of the system consumes this serial line.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz, used to derive bit periods.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `tx_en`  input  1  transmitter enable; when low, no new frame is accepted.
- `tx_wr`  input  1  write strobe; requests transmission of `tx_data`.
- `tx_data`  input  8  encoded word from the encoder output.
- `baud_select`  input  3  bit-rate code: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud.
- `tx_d`  output  1  serial line; idles high.
- `tx_busy`  output  1  high while a frame is in progress.

## Operation
- Reset values:
  - `tx_d` = 1 and `tx_busy` = 0. These take effect immediately, without waiting for a clock edge.
  - The FSM enters IDLE and all counters clear to 0.
- Bit period:
  - P = CLK_FREQ / baud, using integer division and truncating.
  - P is computed per code as a constant. The counter width is $clog2 of the largest P, which is the P for code 0.
- Acceptance:
  - A frame is accepted on a rising edge where `tx_en`=1, `tx_wr`=1 and `tx_busy`=0.
  - On acceptance, `tx_data` and `baud_select` are latched. Changes to either input mid-frame have no effect.
  - A `tx_wr` while busy is ignored and not queued.
  - A `tx_wr` while `tx_en`=0 is ignored.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - START drives 0 for P clocks.
  - DATA drives bit i (i = 0..7, LSB first) for P clocks each, using a 3-bit index counter.
  - PARITY drives the XOR of the 8 latched bits (even parity) for P clocks.
  - STOP drives 1 for P clocks.
- Deasserting `tx_en` mid-frame does not abort the frame; the frame completes normally.
- `tx_d` is registered and must be glitch-free.

## Timing
- Acceptance at edge k produces:
  - `tx_d`=0 and `tx_busy`=1 from edge k+1.
  - Each bit lasts exactly P clocks.
  - The frame lasts 11·P clocks.
  - `tx_busy` falls at edge k+1+11P, and `tx_d` is 1 at that point (end of STOP).
- Back-to-back frames:
  - If `tx_wr` is held high, the next frame is accepted at the first edge where `tx_busy` is sampled low.
  - This gives one idle-high clock between frames.
- Reset asserted mid-frame:
  - `tx_d` returns to 1 and `tx_busy` to 0 asynchronously.
  - The partial frame is discarded, and no frame is accepted while `reset` is high.
- Baud counter:
  - Counts 0..P-1 and wraps to 0.
  - The state or bit index advances on the wrap.
  - The counter is cleared on acceptance so that the start bit is exactly P clocks.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the 8-entry baud table indexed by `baud_select`;
  - the frame constants: data bits 8, frame bits 11.
- One sub-module, `baud_controller`:
  - inputs: `clk`, `reset`, `baud_select`, `clear`;
  - output: a 1-clock `bit_tick` pulse every P clocks.
- The top level contains the FSM, the shift/index logic and the parity register.

## Test plan
All scenarios use CLK_FREQ=1_152_000, which gives P=10 at code 7 and P=3840 at code 0.
- Single frame:
  - Stimulus: `tx_data`=0x23 (encoder output for 0x12), code 7, one `tx_wr` pulse.
  - Required `tx_d` sequence, 10 clocks each: 0, 1,1,0,0,0,1,0,0, 1 (parity), 1 (stop).
  - `tx_busy` is high for exactly 110 clocks.
- Busy and enable:
  - A `tx_wr` with `tx_data`=0xFF during the 0x23 frame is ignored: the frame is unchanged and no second frame follows.
  - A `tx_wr` with `tx_en`=0 produces no frame.
- Back-to-back:
  - Stimulus: `tx_wr` held high with 0x00.
  - Required response: frames of 0, 8×0, parity 0, 1, separated by exactly one idle-high clock.
- Input stability:
  - Stimulus: `baud_select` changed from 7 to 0, and `tx_data` changed, during a frame.
  - Required response: the current frame keeps 10-clock bits and the original data.
  - The next frame uses 3840-clock bits.
- Reset mid-frame:
  - Stimulus: `reset` asserted during DATA bit 3.
  - Required response: `tx_d`=1 and `tx_busy`=0 within the same cycle, without a clock edge.
  - After release, a new `tx_wr` produces a clean full frame.
